// File: rtl/read_master_arbiter.sv
// read_master_arbiter: round-robin scheduler sharing one AXI read master among C_NUM_REQ requesters,
// routing the read stream to the job owner and pulsing a per-requester done once every beat is delivered.
module read_master_arbiter #(
  parameter int C_NUM_REQ          = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 64,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_MAX_BURST_LENGTH = 256
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [C_NUM_REQ-1:0]                    req_valid,
  output logic [C_NUM_REQ-1:0]                    req_ready,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_NUM_REQ*C_XFER_SIZE_WIDTH-1:0]  req_size,
  output logic [C_NUM_REQ-1:0]                    req_done,
  output logic [C_NUM_REQ-1:0]                    req_err,
  output logic                                    rm_ctrl_start,
  input  logic                                    rm_ctrl_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           rm_ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]            rm_ctrl_xfer_size_in_bytes,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                                    s_axis_tlast,
  output logic [C_NUM_REQ-1:0]                    m_axis_tvalid,
  input  logic [C_NUM_REQ-1:0]                    m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                    m_axis_tlast,
  output logic                                    busy,
  output logic [$clog2(C_NUM_REQ)-1:0]            owner
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int XW    = C_XFER_SIZE_WIDTH;
  localparam int OW    = $clog2(C_NUM_REQ);
  localparam int DWB   = C_M_AXI_DATA_WIDTH / 8;
  localparam int LG    = $clog2(DWB);
  localparam int BW    = XW - LG + 1;
  localparam int BURST = (4096 / DWB < C_MAX_BURST_LENGTH) ? 4096 / DWB : C_MAX_BURST_LENGTH;
  localparam int AL    = $clog2(DWB * BURST);
  localparam logic [C_NUM_REQ-1:0] ONE = 1;
  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;
  state_t          r_state, w_next;
  logic [OW-1:0]   r_owner, r_last_grant, w_grant;
  logic [OW:0]     w_idx;
  logic            w_found, w_misal, w_hs, w_seen_nxt, r_done_seen, r_err, w_unused;
  logic [AW-1:0]   r_addr, w_addr;
  logic [XW-1:0]   r_size, w_size;
  logic [BW-1:0]   r_beats_exp, r_beat_cnt, w_beats, w_beat_nxt;

  assign w_unused = s_axis_tlast;

  // Scan downward so the last hit is the nearest requester above last_grant.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    for (int k = C_NUM_REQ; k >= 1; k--) begin
      w_idx = {1'b0, r_last_grant} + (OW+1)'(k);
      w_idx = (w_idx >= (OW+1)'(C_NUM_REQ)) ? w_idx - (OW+1)'(C_NUM_REQ) : w_idx;
      if (req_valid[w_idx[OW-1:0]]) w_grant = w_idx[OW-1:0];
    end
    w_found = |req_valid;
    w_addr  = '0;
    w_size  = '0;
    for (int i = 0; i < C_NUM_REQ; i++)
      if (w_grant == OW'(i)) begin
        w_addr = req_addr[i*AW +: AW];
        w_size = req_size[i*XW +: XW];
      end
    w_misal    = |w_addr[AL-1:0];
    w_beats    = {1'b0, w_size[XW-1:LG]} + BW'(|w_size[LG-1:0]);
    w_beat_nxt = r_beat_cnt + BW'(w_hs);
    w_seen_nxt = r_done_seen | rm_ctrl_done;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;

  // Exit looks ahead at this cycle's beat and done so req_done follows the last beat by one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = (w_size == '0 || w_misal) ? S_DONE : S_START;
      S_START: w_next = S_BUSY;
      S_BUSY:  if (w_seen_nxt && w_beat_nxt == r_beats_exp) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (r_state == S_IDLE && w_found) ? ONE << w_grant : '0;
    rm_ctrl_start = r_state == S_START;
    req_done      = (r_state == S_DONE) ? ONE << r_owner : '0;
    req_err       = (r_state == S_DONE && r_err) ? ONE << r_owner : '0;
    s_axis_tready = (r_state == S_BUSY) && m_axis_tready[r_owner];
    m_axis_tvalid = (r_state == S_BUSY && s_axis_tvalid) ? ONE << r_owner : '0;
    m_axis_tdata  = (r_state == S_BUSY) ? s_axis_tdata : '0;
    m_axis_tlast  = (r_state == S_BUSY) && r_beat_cnt == r_beats_exp - BW'(1);
    busy          = r_state != S_IDLE;
  end

  assign w_hs                       = s_axis_tvalid & s_axis_tready;
  assign owner                      = r_owner;
  assign rm_ctrl_addr_offset        = r_addr;
  assign rm_ctrl_xfer_size_in_bytes = r_size;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_owner      <= '0;
      r_last_grant <= OW'(C_NUM_REQ - 1);
      r_addr       <= '0;
      r_size       <= '0;
      r_beats_exp  <= '0;
      r_beat_cnt   <= '0;
      r_done_seen  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_owner     <= w_grant;
        r_addr      <= w_addr;
        r_size      <= w_size;
        r_beats_exp <= w_beats;
        r_err       <= w_misal;
      end
      if (r_state == S_BUSY) begin
        r_beat_cnt  <= w_beat_nxt;
        r_done_seen <= w_seen_nxt;
      end
      if (r_state == S_DONE) begin
        r_last_grant <= r_owner;
        r_beat_cnt   <= '0;
        r_done_seen  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_read_master_arbiter.sv
// tb_read_master_arbiter: random and directed jobs against a job-level round-robin / beat-count model.
module tb_read_master_arbiter;
  localparam int N = 4, AW = 64, XW = 64, DW = 128;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_done, req_err;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*XW-1:0] req_size = '0;
  logic rm_ctrl_start, rm_ctrl_done = 1'b0;
  logic [AW-1:0] rm_ctrl_addr_offset;
  logic [XW-1:0] rm_ctrl_xfer_size_in_bytes;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [N-1:0] m_axis_tvalid, m_axis_tready = '0;
  logic m_axis_tlast, busy;
  logic [1:0] owner;
  int n_chk = 0, n_pass = 0, m_last = N - 1;

  always #5 aclk = ~aclk;

  read_master_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_done(req_done), .req_err(req_err),
    .rm_ctrl_start(rm_ctrl_start), .rm_ctrl_done(rm_ctrl_done),
    .rm_ctrl_addr_offset(rm_ctrl_addr_offset), .rm_ctrl_xfer_size_in_bytes(rm_ctrl_xfer_size_in_bytes),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic set_job(input int i, input logic [AW-1:0] a, input logic [XW-1:0] s);
    req_addr[i*AW +: AW] = a;
    req_size[i*XW +: XW] = s;
  endtask

  // mode: 0 = read-master done on first streaming cycle, 1 = with last beat, 2 = three cycles after
  task automatic do_round(input logic [N-1:0] v, input int mode, input int rdy_pct);
    int g, exp_beats, sent, post, c;
    logic [AW-1:0] a;
    logic [XW-1:0] sz;
    logic bad, seen, hs, tv;
    logic [N-1:0] rdy;
    logic [DW-1:0] d;
    @(negedge aclk);
    req_valid = v;
    #1;
    g = pick(v);
    chk("grant", req_ready, 128'(1) << g);
    a = req_addr[g*AW +: AW];
    sz = req_size[g*XW +: XW];
    bad = a[11:0] != 12'h0;
    exp_beats = int'((sz + 15) / 16);
    @(negedge aclk);
    req_valid[g] = 1'b0;
    s_axis_tvalid = 1'b1;
    #1;
    chk("owner", owner, 128'(g));
    chk("stall_rdy", s_axis_tready, 0);
    chk("stall_vld", m_axis_tvalid, 0);
    chk("stall_last", m_axis_tlast, 0);
    if (bad || sz == 0) begin
      chk("skip_start", rm_ctrl_start, 0);
      chk("skip_done", req_done, 128'(1) << g);
      chk("skip_err", req_err, bad ? 128'(1) << g : 128'(0));
      m_last = g;
      s_axis_tvalid = 1'b0;
      return;
    end
    chk("start", rm_ctrl_start, 1);
    chk("addr", rm_ctrl_addr_offset, a);
    chk("size", rm_ctrl_xfer_size_in_bytes, sz);
    chk("done_early", req_done, 0);
    sent = 0; post = 0; c = 0; seen = 1'b0;
    while (!(seen && sent == exp_beats) && c < 5000) begin
      @(negedge aclk);
      tv = sent < exp_beats && $urandom_range(99) < 70;
      rdy = N'($urandom);
      rdy[g] = $urandom_range(99) < rdy_pct;
      d = {$urandom, $urandom, $urandom, $urandom};
      hs = tv && rdy[g];
      s_axis_tvalid = tv;
      s_axis_tdata = d;
      s_axis_tlast = (sent % 256 == 255) || sent == exp_beats - 1;
      m_axis_tready = rdy;
      rm_ctrl_done = (mode == 0 && c == 0) || (mode == 1 && hs && sent == exp_beats - 1) || (mode == 2 && post == 3);
      #1;
      chk("m_vld", m_axis_tvalid, tv ? 128'(1) << g : 128'(0));
      chk("s_rdy", s_axis_tready, rdy[g]);
      chk("m_last", m_axis_tlast, sent == exp_beats - 1);
      if (tv) chk("m_data", m_axis_tdata, d);
      chk("no_done", req_done, 0);
      chk("no_ready", req_ready, 0);
      sent += int'(hs);
      seen |= rm_ctrl_done;
      if (sent == exp_beats) post++;
      c++;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    rm_ctrl_done = 1'b0;
    m_axis_tready = '1;
    #1;
    chk("drained", sent, exp_beats);
    chk("done", req_done, 128'(1) << g);
    chk("err", req_err, 0);
    chk("done_stall", s_axis_tready, 0);
    m_last = g;
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_start", rm_ctrl_start, 0);
    chk("rst_size", rm_ctrl_xfer_size_in_bytes, 0);
    chk("rst_vld", m_axis_tvalid, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    set_job(0, 64'h0, 64);
    do_round(4'b0001, 2, 100);
    set_job(1, 64'h1000, 4100);
    do_round(4'b0010, 1, 60);
    for (int i = 0; i < N; i++) set_job(i, 64'(i + 1) << 12, 64'(16 * (i + 1) + 3));
    repeat (8) do_round(4'b1111, 0, 80);
    do_round(4'b1111, 2, 80);
    do_round(4'b1011, 2, 80);
    do_round(4'b1011, 2, 80);
    set_job(1, 64'h2000, 64 * 16);
    do_round(4'b0010, 0, 50);
    do_round(4'b0010, 1, 50);
    set_job(2, 64'h3000, 0);
    do_round(4'b0100, 2, 100);
    set_job(3, 64'h40, 64);
    do_round(4'b1000, 2, 100);
    @(negedge aclk);
    rm_ctrl_done = 1'b1;
    @(negedge aclk);
    rm_ctrl_done = 1'b0;
    set_job(0, 64'h0, 48);
    do_round(4'b0001, 2, 100);
    repeat (30) begin
      for (int i = 0; i < N; i++)
        set_job(i, ($urandom_range(7) == 0) ? 64'h40 : 64'($urandom_range(255)) << 12, 64'($urandom_range(200)));
      do_round(N'($urandom_range(1, 15)), $urandom_range(2), $urandom_range(30, 100));
    end
    set_job(0, 64'h0, 1024);
    @(negedge aclk);
    req_valid = 4'b0001;
    @(negedge aclk);
    req_valid = '0;
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    m_axis_tready = '1;
    repeat (10) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_owner", owner, 0);
    chk("arst_size", rm_ctrl_xfer_size_in_bytes, 0);
    chk("arst_vld", m_axis_tvalid, 0);
    chk("arst_rdy", s_axis_tready, 0);
    chk("arst_data", m_axis_tdata, 0);
    chk("arst_done", req_done, 0);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    m_last = N - 1;
    for (int i = 0; i < N; i++) set_job(i, 64'(i) << 12, 64'(32));
    do_round(4'b1111, 1, 100);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/read_master_arbiter.md
# read_master_arbiter

Round-robin scheduler that shares one `axi_read_master` instance between `C_NUM_REQ` requesters. It accepts read jobs as (address, byte count) pairs and serialises them: it drives the read master's `ctrl_start`, `ctrl_addr_offset` and `ctrl_xfer_size_in_bytes`, and routes the read master's AXI4-Stream output to the owning requester. It also regenerates a transfer-level `tlast` and returns a per-requester done pulse once every beat of the job has been delivered.

## Interface
- `C_NUM_REQ`, 4: number of requesters, 2..16.
- `C_M_AXI_ADDR_WIDTH`, 64: job address width; must match the read master.
- `C_XFER_SIZE_WIDTH`, 64: job byte-count width; must match the read master.
- `C_M_AXI_DATA_WIDTH`, 128: stream data width; must match the read master.
- `C_MAX_BURST_LENGTH`, 256: read master burst length; sets the address alignment check.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset. One clock; reset is asynchronous and active-low. The top level drives the read master's `areset` from `~aresetn`.
- `req_valid` in `C_NUM_REQ`: job request, one bit per requester.
- `req_ready` out `C_NUM_REQ`: job accepted (one-hot, single-cycle).
- `req_addr` in `C_NUM_REQ*C_M_AXI_ADDR_WIDTH`: packed job addresses; requester i occupies slice i.
- `req_size` in `C_NUM_REQ*C_XFER_SIZE_WIDTH`: packed job byte counts.
- `req_done` out `C_NUM_REQ`: single-cycle pulse when the job is complete.
- `req_err` out `C_NUM_REQ`: single-cycle pulse, coincident with `req_done`, when the job address was misaligned.
- `rm_ctrl_start` out 1: start pulse to the read master.
- `rm_ctrl_done` in 1: done pulse from the read master.
- `rm_ctrl_addr_offset` out `C_M_AXI_ADDR_WIDTH`: job address to the read master.
- `rm_ctrl_xfer_size_in_bytes` out `C_XFER_SIZE_WIDTH`: job byte count to the read master.
- `s_axis_tvalid`, `s_axis_tready`, `s_axis_tdata`, `s_axis_tlast` (in/out/in/in): stream from the read master. `s_axis_tlast` marks burst ends and is ignored.
- `m_axis_tvalid` out `C_NUM_REQ`: per-requester stream valid.
- `m_axis_tready` in `C_NUM_REQ`: per-requester stream ready.
- `m_axis_tdata` out `C_M_AXI_DATA_WIDTH`: stream data, shared by all requesters.
- `m_axis_tlast` out 1: transfer-level last beat.
- `busy` out 1: a job is in flight.
- `owner` out `$clog2(C_NUM_REQ)`: index of the current or last granted requester.

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- **IDLE:**
  - Arbitration picks requester g: the first asserted `req_valid` searching upward from `last_grant+1`, wrapping at `C_NUM_REQ`.
  - `req_ready[g]=1` combinationally in that cycle.
  - Latch g, addr and size into `owner`/`addr_r`/`size_r`.
  - Compute `beats_exp = ceil(size/(C_M_AXI_DATA_WIDTH/8))`.
  - Next state is START; if size==0 or the address is misaligned, next state is DONE instead.
- **Misaligned address:** low `$clog2(DW_BYTES*min(4096/DW_BYTES, C_MAX_BURST_LENGTH))` bits non-zero. Such a job is never issued; `req_err` pulses with `req_done`.
- **START:**
  - `rm_ctrl_start=1` for exactly one cycle.
  - `rm_ctrl_addr_offset`/`rm_ctrl_xfer_size_in_bytes` are driven from the registers and held stable until the next grant.
  - Next state: BUSY.
- **BUSY:**
  - Stream routing: `m_axis_tvalid[owner]=s_axis_tvalid`, other bits 0; `s_axis_tready=m_axis_tready[owner]`; `m_axis_tdata=s_axis_tdata`.
  - The beat counter increments on `s_axis_tvalid & s_axis_tready`.
  - `m_axis_tlast=1` when `beat_cnt==beats_exp-1`.
  - `rm_ctrl_done` sets a sticky `rm_done_seen`.
  - Exit to DONE when `rm_done_seen` is set and `beat_cnt==beats_exp`. The two conditions may arrive in either order or in the same cycle.
- **DONE:**
  - `req_done[owner]=1` for one cycle.
  - `last_grant<=owner`; clear the counter and `rm_done_seen`.
  - Next state: IDLE.
- **Outside BUSY:** `s_axis_tready=0`, all `m_axis_tvalid=0`, `m_axis_tlast=0`. Stray beats are stalled, never dropped.
- **Arithmetic:**
  - Beat counter width: `C_XFER_SIZE_WIDTH-$clog2(DW_BYTES)+1`.
  - `beats_exp` rounds up on a partial final word. This matches the read master's round-up.
- `busy=1` in START, BUSY and DONE.

## Timing
- Reset values:
  - State: IDLE.
  - `last_grant`: `C_NUM_REQ-1`, so requester 0 wins the first arbitration.
  - All outputs 0, including `owner` and the rm_ctrl buses.
- Latency:
  - `req_valid` in IDLE to `req_ready`: 0 cycles.
  - `req_ready` to `rm_ctrl_start`: 1 cycle.
  - Final accepted beat (with `rm_done_seen` set) to `req_done`: 1 cycle.
  - `req_done` to the next `req_ready`: 1 cycle.
  - A zero-size or misaligned job completes with `req_done` 1 cycle after `req_ready`.
- Requesters hold `req_valid`/`req_addr`/`req_size` until `req_ready`. Deasserting `req_valid` early withdraws the request without side effects.
- If `rm_ctrl_done` arrives outside BUSY, it is ignored.
- Asynchronous reset mid-job returns to IDLE at once. No `req_done` is issued for the aborted job, and the read master is reset by the same event.

## Test plan
- Single job, req 0: addr 0x0, size 64, 128-bit data -> `req_ready[0]`, `rm_ctrl_start` next cycle, 4 beats on `m_axis_tvalid[0]` with `m_axis_tlast` on beat 4 only, then `req_done[0]`.
- Partial word and burst tlast: size 4100, 16 B words -> `beats_exp`=257. `m_axis_tlast` asserts only on beat 257, even though `s_axis_tlast` asserts on beats 256 and 257.
- Round-robin fairness: all 4 requesters hold valid for 8 jobs -> grant order 0,1,2,3,0,1,2,3. Requester 2 withdrawing before its turn -> order 0,1,3.
- Done ordering: the read master's `rm_ctrl_done` arrives 20 cycles before the sink drains, with `m_axis_tready[1]` toggling 50% -> `req_done[1]` exactly 1 cycle after the last beat. Same-cycle done and last beat -> `req_done` next cycle.
- Zero size and misaligned: size 0 -> `req_done` with no `rm_ctrl_start`. Addr 0x40 (burst 256, 16 B words) -> `req_done` and `req_err` together, no start.
- Reset mid-BUSY after 10 of 64 beats -> all outputs 0 asynchronously. After release, a new request from req 0 is granted first.
